// File: rtl/valve_ctrl_pkg.sv
// Shared definitions for valve_ctrl: command field layout and FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package valve_ctrl_pkg;

    // Burst length occupies the low bits of the command word.
    localparam int CMD_LEN_LSB = 0;

    // MSB of the LEN field for a given counter width.
    function automatic int cmd_len_msb(input int cnt_w);
        return cnt_w - 1;
    endfunction

    // PASS flag sits directly above the LEN field.
    function automatic int cmd_pass_bit(input int cnt_w);
        return cnt_w;
    endfunction

    // IDLE: no burst in progress (counter at zero). BURST: mid-burst.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/valve_ctrl_dreg.sv
// Single-entry valid/ready output register, empty after reset.
// Latency: one cycle from load to out_vld_o.
// Backpressure: space_o is high when empty or draining this cycle; load only when space_o.
module valve_ctrl_dreg #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] dat_i,
    output logic         space_o,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);
    import valve_ctrl_pkg::*;

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    assign space_o   = !vld_q || out_rdy_i;
    assign out_vld_o = vld_q;
    assign out_dat_o = dat_q;

    // Next state: a load wins over a drain, so load+transfer keeps the entry full.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_i) begin
            vld_d = 1'b1;
            dat_d = dat_i;
        end else if (out_rdy_i) begin
            vld_d = 1'b0;
        end
    end

    // Register with synchronous reset to the empty state.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: rtl/valve_ctrl.sv
// Gates a data stream in command-sized bursts, forwarding (PASS) or dropping items.
// Latency: one cycle din -> dout in PASS mode; cmd consumed with the last item.
// Backpressure: PASS stalls din while dout is full and not draining; drop never stalls.
module valve_ctrl #(
    parameter int DIN = 16,
    parameter int CNT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [CNT:0]   cmd_data,
    input  logic           din_valid,
    output logic           din_ready,
    input  logic [DIN-1:0] din_data,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic [DIN:0]   dout_data
);
    import valve_ctrl_pkg::*;

    localparam int LEN_MSB  = cmd_len_msb(CNT);
    localparam int PASS_BIT = cmd_pass_bit(CNT);

    state_e         state_q, state_d;
    logic [CNT-1:0] cnt_q, cnt_d;

    logic [CNT-1:0] cmd_len;
    logic [CNT-1:0] len_m1;
    logic [CNT-1:0] cur_cnt;
    logic           cmd_pass;
    logic           len_zero;
    logic           last_item;
    logic           out_space;
    logic           accept;
    logic           load;

    assign cmd_len  = cmd_data[LEN_MSB:CMD_LEN_LSB];
    assign cmd_pass = cmd_data[PASS_BIT];
    assign len_zero = (cmd_len == '0);
    assign len_m1   = cmd_len - CNT'(1);

    // Handshakes, counter and FSM next state; all defaults first.
    always_comb begin
        cur_cnt   = (state_q == ST_IDLE) ? '0 : cnt_q;
        last_item = (cur_cnt == len_m1);
        din_ready = 1'b0;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        cnt_d     = cnt_q;
        state_d   = state_q;
        if (!rst && cmd_valid) begin
            if (len_zero) begin
                cmd_ready = 1'b1;
            end else begin
                din_ready = cmd_pass ? out_space : 1'b1;
                accept    = din_valid && din_ready;
                load      = accept && cmd_pass;
                if (accept) begin
                    cmd_ready = last_item;
                    cnt_d     = last_item ? '0 : cur_cnt + CNT'(1);
                end
            end
        end
        state_d = (cnt_d != '0) ? ST_BURST : ST_IDLE;
    end

    // State and item counter; reset discards any partial burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    valve_ctrl_dreg #(
        .W (DIN + 1)
    ) dreg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .dat_i     ({last_item, din_data}),
        .space_o   (out_space),
        .out_vld_o (dout_valid),
        .out_rdy_i (dout_ready),
        .out_dat_o (dout_data)
    );

endmodule

// File: doc/valve_ctrl.md
VALVE_CTRL -- requirements
Module: valve_ctrl

Interface
REQ-001 SHALL have parameter DIN, default 16: data width of the din and dout payloads.
REQ-002 SHALL have parameter CNT, default 8: width of the burst-length field in cmd.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1) and cmd_data (input, CNT+1). cmd_data[CNT-1:0] is the burst length LEN. cmd_data[CNT] is PASS (1 = forward, 0 = drop).
REQ-006 SHALL have ports din_valid (input, 1), din_ready (output, 1) and din_data (input, DIN): the gated data stream.
REQ-007 SHALL have ports dout_valid (output, 1), dout_ready (input, 1) and dout_data (output, DIN+1). dout_data[DIN] is LAST (final item of the burst); dout_data[DIN-1:0] is the payload.

Function
REQ-008 SHALL follow the valid/ready rule: a transfer occurs on a cycle where valid and ready are both high. Inputs are not required to hold stable until transfer, but cmd_data SHALL be treated as stable while cmd_valid is high.
REQ-009 SHALL use a two-state FSM: IDLE and BURST. The state is BURST whenever the item counter cnt is nonzero or an item is accepted this cycle under a cmd with LEN>1. It is IDLE otherwise.
REQ-010 SHALL accept no din while cmd_valid is low: din_ready=0 and cnt holds.
REQ-011 SHALL, in PASS mode, set din_ready = cmd_valid AND (NOT dout_valid OR dout_ready). dout is a single output register with no skid buffer.
REQ-012 SHALL, on each accepted din item in PASS mode, load the dout register on the same clock edge: payload = din_data, LAST = (cnt == LEN-1). dout_valid rises the cycle after acceptance, giving 1-cycle latency.
REQ-013 SHALL, in drop mode (PASS=0), set din_ready = cmd_valid and consume din without writing the dout register.
REQ-014 SHALL increment cnt on each accepted din item. On the item where cnt == LEN-1, cnt SHALL return to 0 and cmd_ready SHALL be 1 in that same cycle; this is combinational and consumes the cmd together with the last item.
REQ-015 SHALL, when LEN == 0, assert cmd_ready=1 combinationally while cmd_valid is high, keep din_ready=0, and emit nothing on dout.
REQ-016 SHALL hold cmd_ready=0 in all cases other than REQ-014 and REQ-015.
REQ-017 SHALL clear dout_valid on a dout transfer unless a new item is loaded the same cycle. A simultaneous load and transfer SHALL keep dout_valid=1 with the new item.
REQ-018 SHALL apply back-to-back commands with no idle cycle: the cycle after cmd consumption may accept the first item of the next cmd.
REQ-019 SHALL treat cnt as CNT bits wide; LEN = 2^CNT-1 is the maximum burst, and cnt never wraps past LEN-1.
REQ-020 SHALL never assert LAST except on the final item of a PASS burst.

Reset
REQ-021 SHALL, while rst is high at a clock edge, set cnt=0, dout_valid=0, dout_data=0 and FSM=IDLE.
REQ-022 SHALL, on reset mid-burst, discard progress: the still-pending cmd (not yet consumed) restarts from item 0 after reset.
REQ-023 SHALL drive din_ready=0 and cmd_ready=0 in any cycle where rst is high.

Structure
REQ-024 SHALL place the cmd field offsets (LEN lsb/msb, PASS bit index) and the FSM state encoding in a shared package, valve_ctrl_pkg.
REQ-025 SHALL implement the dout register as one sub-module, dreg: a single-entry valid/ready register with a reset-to-empty state. The FSM and counter stay in valve_ctrl.

Verification
REQ-026 SHALL cover a PASS burst with DIN=16: cmd {PASS=1, LEN=3}, din 0xA,0xB,0xC, dout_ready=1 -> dout 0xA,0xB,0xC on consecutive cycles with LAST only on 0xC; cmd_ready pulses once, with 0xC accepted.
REQ-027 SHALL cover drop mode: cmd {PASS=0, LEN=4}, 4 din items -> din_ready=1 for 4 transfers, dout_valid stays 0, cmd_ready pulses on the 4th item.
REQ-028 SHALL cover zero length: cmd {PASS=1, LEN=0} with din_valid=1 -> cmd_ready=1 in the same cycle, din_ready=0, no dout.
REQ-029 SHALL cover backpressure: LEN=2 with dout_ready=0 for 3 cycles after the first item -> din_ready=0 while dout is full; both items arrive in order with LAST on the second.
REQ-030 SHALL cover reset mid-burst: LEN=5, rst pulsed after 2 items -> dout_valid=0 next cycle, then 5 further items are required before cmd_ready rises.
REQ-031 SHALL cover back-to-back commands: {1,2} then {0,1} -> 2 forwarded items, 1 dropped item, 3 consecutive din transfers with no gap.
